// File: rtl/udb_pkg.sv
// Shared constants for the counter-with-shifter datapath.
package udb_pkg;

    parameter int unsigned WIDTH_DEFAULT = 32;
    parameter int unsigned SHAMT_W = $clog2(WIDTH_DEFAULT);

    parameter logic DIR_UP      = 1'b0;
    parameter logic DIR_DOWN    = 1'b1;
    parameter logic SR_SHIFT    = 1'b0;
    parameter logic SR_ROTATE   = 1'b1;
    parameter logic SHIFT_LEFT  = 1'b0;
    parameter logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/udb_barrel_shifter_shifter.sv
// Combinational log shifter: stage k moves the data by 2^k when shamt[k] is set,
// either wrapping (rotate) or zero-filling (logical shift).
module barrel_shifter
    import udb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0]         data,
    input  logic                     sr,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     dir,
    output logic [WIDTH-1:0]         result
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [SW:0][WIDTH-1:0] stage;

    assign stage[0] = data;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int unsigned Amt = 2 ** k;

        logic [WIDTH-1:0] shl, shr, rol, ror, moved;

        assign shl = stage[k] << Amt;
        assign shr = stage[k] >> Amt;
        assign rol = shl | (stage[k] >> (WIDTH - Amt));
        assign ror = shr | (stage[k] << (WIDTH - Amt));

        always_comb begin
            moved = shl;
            if (dir == SHIFT_RIGHT) begin
                moved = (sr == SR_ROTATE) ? ror : shr;
            end else begin
                moved = (sr == SR_ROTATE) ? rol : shl;
            end
        end

        assign stage[k+1] = shamt[k] ? moved : stage[k];
    end

    assign result = stage[SW];

endmodule

// File: rtl/udb_barrel_shifter.sv
// Prescaled up/down counter whose registered value feeds a combinational barrel shifter.
module udb_barrel_shifter
    import udb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DIV   = 1
) (
    input  logic                     udb_barrel_shifter_clk,
    input  logic                     udb_barrel_shifter_rst,
    input  logic                     udb_barrel_shifter_direction,
    input  logic                     udb_barrel_shifter_sr,
    input  logic [$clog2(WIDTH)-1:0] udb_barrel_shifter_shift,
    input  logic                     udb_barrel_shifter_shift_dir,
    output logic [WIDTH-1:0]         udb_barrel_shifter_count,
    output logic [WIDTH-1:0]         udb_barrel_shifter_output
);

    localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PreW-1:0]  pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             step;

    assign step = (pre_q == PreW'(DIV - 1));

    always_comb begin
        pre_d   = step ? '0 : pre_q + PreW'(1);
        count_d = count_q;
        if (step) begin
            count_d = (udb_barrel_shifter_direction == DIR_DOWN) ? count_q - WIDTH'(1)
                                                                 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge udb_barrel_shifter_clk or posedge udb_barrel_shifter_rst) begin
        if (udb_barrel_shifter_rst) begin
            pre_q   <= '0;
            count_q <= '0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign udb_barrel_shifter_count = count_q;

    barrel_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .data   (count_q),
        .sr     (udb_barrel_shifter_sr),
        .shamt  (udb_barrel_shifter_shift),
        .dir    (udb_barrel_shifter_shift_dir),
        .result (udb_barrel_shifter_output)
    );

endmodule

// File: tb/tb_udb_barrel_shifter.sv
// Randomised and directed checks of the counter/shifter against an arithmetic reference model.
module tb_udb_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        direction;
    logic        sr;
    logic [4:0]  shift;
    logic        shift_dir;
    logic [31:0] count, out_w;
    logic [31:0] count4, out4;
    logic [31:0] sh_data, sh_res;
    logic        sh_sr, sh_dir;
    logic [4:0]  sh_amt;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] ref_cnt;
    int unsigned ticks;

    always #5 clk = ~clk;

    udb_barrel_shifter #(.WIDTH(32), .DIV(1)) dut (
        .udb_barrel_shifter_clk       (clk),
        .udb_barrel_shifter_rst       (rst),
        .udb_barrel_shifter_direction (direction),
        .udb_barrel_shifter_sr        (sr),
        .udb_barrel_shifter_shift     (shift),
        .udb_barrel_shifter_shift_dir (shift_dir),
        .udb_barrel_shifter_count     (count),
        .udb_barrel_shifter_output    (out_w)
    );

    udb_barrel_shifter #(.WIDTH(32), .DIV(4)) dut4 (
        .udb_barrel_shifter_clk       (clk),
        .udb_barrel_shifter_rst       (rst),
        .udb_barrel_shifter_direction (1'b0),
        .udb_barrel_shifter_sr        (1'b0),
        .udb_barrel_shifter_shift     (5'd0),
        .udb_barrel_shifter_shift_dir (1'b0),
        .udb_barrel_shifter_count     (count4),
        .udb_barrel_shifter_output    (out4)
    );

    // Standalone shifter for data patterns the counter cannot reach quickly.
    barrel_shifter #(.WIDTH(32)) u_shf (
        .data   (sh_data),
        .sr     (sh_sr),
        .shamt  (sh_amt),
        .dir    (sh_dir),
        .result (sh_res)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic rot,
                                               input int s, input logic right);
        logic [63:0] w;
        if (!rot) return right ? (d >> s) : (d << s);
        if (right) begin
            w = {d, d} >> s;
            return w[31:0];
        end
        w = {d, d} << s;
        return w[63:32];
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_cnt"}, count, ref_cnt);
        check({tag, "_out"}, out_w, ref_shift(ref_cnt, sr, int'(shift), shift_dir));
        check({tag, "_cnt4"}, count4, 32'(ticks / 4));
        check({tag, "_out4"}, out4, 32'(ticks / 4));
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (!rst) begin
            ref_cnt = direction ? ref_cnt - 32'd1 : ref_cnt + 32'd1;
            ticks++;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ref_cnt = '0;
        ticks = 0;
        #1;
        check_all("rst_async");
        edge_step();
        check_all("rst_hold");
        rst = 1'b0;
    endtask

    task automatic shf(input string tag, input logic [31:0] d, input logic rot,
                       input logic right, input logic [4:0] amt, input logic [31:0] exp);
        sh_data = d; sh_sr = rot; sh_dir = right; sh_amt = amt;
        #1;
        check(tag, sh_res, exp);
        check({tag, "_model"}, sh_res, ref_shift(d, rot, int'(amt), right));
    endtask

    initial begin
        rst = 1'b1; direction = 1'b0; sr = 1'b0; shift = '0; shift_dir = 1'b0;
        sh_data = '0; sh_sr = 1'b0; sh_amt = '0; sh_dir = 1'b0;
        ref_cnt = '0; ticks = 0;
        #2;
        check_all("reset");
        edge_step();
        check_all("reset_held");
        rst = 1'b0;

        // Count up from reset; DIV=4 instance advances every fourth edge.
        for (int i = 1; i <= 8; i++) begin
            edge_step();
            check_all($sformatf("up%0d", i));
        end
        check("up_count_is_8", count, 32'd8);
        check("div4_after8", count4, 32'd2);

        // Wrap-around both ways.
        apply_reset();
        direction = 1'b1;
        edge_step();
        check("wrap_dn1", count, 32'hFFFF_FFFF);
        edge_step();
        check("wrap_dn2", count, 32'hFFFF_FFFE);
        direction = 1'b0;
        edge_step();
        edge_step();
        check("wrap_up", count, 32'h0000_0000);

        // Directed shifter vectors.
        shf("m_shl1", 32'h8000_0001, 1'b0, 1'b0, 5'd1, 32'h0000_0002);
        shf("m_shr1", 32'h8000_0001, 1'b0, 1'b1, 5'd1, 32'h4000_0000);
        shf("m_rol1", 32'h8000_0001, 1'b1, 1'b0, 5'd1, 32'h0000_0003);
        shf("m_ror1", 32'h8000_0001, 1'b1, 1'b1, 5'd1, 32'hC000_0000);
        shf("x_shl31", 32'h0000_000F, 1'b0, 1'b0, 5'd31, 32'h8000_0000);
        shf("x_rol31", 32'h0000_000F, 1'b1, 1'b0, 5'd31, 32'h8000_0007);
        shf("x_shr31", 32'h0000_000F, 1'b0, 1'b1, 5'd31, 32'h0000_0000);
        shf("x_ror0", 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            logic [4:0] a;
            logic [31:0] e;
            d = $urandom;
            a = 5'($urandom_range(31));
            sh_sr = 1'($urandom);
            sh_dir = 1'($urandom);
            e = ref_shift(d, sh_sr, int'(a), sh_dir);
            shf($sformatf("shf_rand%0d", i), d, sh_sr, sh_dir, a, e);
        end

        // Random direction and shifter controls, changed between edges.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            direction = 1'($urandom);
            sr = 1'($urandom);
            shift = 5'($urandom);
            shift_dir = 1'($urandom);
            #2;
            check_all($sformatf("rnd_mid%0d", i));
            edge_step();
            check_all($sformatf("rnd_edge%0d", i));
        end

        // Asynchronous reset mid-count at 0x123.
        apply_reset();
        direction = 1'b0; sr = 1'b1; shift = 5'd7; shift_dir = 1'b0;
        for (int i = 0; i < 32'h123; i++) edge_step();
        check_all("pre_async");
        check("cnt_123", count, 32'h0000_0123);
        #2;
        rst = 1'b1;
        ref_cnt = '0;
        ticks = 0;
        #1;
        check("async_cnt", count, 32'h0);
        check("async_out", out_w, 32'h0);
        edge_step();
        edge_step();
        check_all("async_held");
        rst = 1'b0;
        edge_step();
        check_all("after_release");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
